// File: rtl/jzjpcc_fetch_queue_pkg.sv
// ============================================================================
// Module      : jzjpcc_pkg
// Description : Shared constants and types for the jzjpcc fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jzjpcc_pkg;

    // addi x0, x0, 0 - presented to decode whenever no real instruction exists
    localparam logic [31:0] NOP_INSTRUCTION      = 32'h00000013;

    // Byte address of the first fetch after reset
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h00000000;

    // One buffered fetch result: the instruction word and its byte PC
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/jzjpcc_fetch_queue_if.sv
// ============================================================================
// Module      : jzjpcc_fetch_queue_if
// Description : Instruction-memory and decode-side signals of the fetch stage.
//               master = fetch stage, slave = memory/decode environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jzjpcc_fetch_queue_if;

    // Instruction memory port
    logic [29:0] instructionAddress;
    logic        instructionRequest;
    logic [31:0] instructionData;

    // Decode / execute side
    logic        stall_decode;
    logic        redirect;
    logic [31:0] redirectAddress;
    logic [31:0] instruction_decode;
    logic [31:0] pc_decode;
    logic        valid_decode;

    modport master (
        output instructionAddress,
        output instructionRequest,
        input  instructionData,
        input  stall_decode,
        input  redirect,
        input  redirectAddress,
        output instruction_decode,
        output pc_decode,
        output valid_decode
    );

    modport slave (
        input  instructionAddress,
        input  instructionRequest,
        output instructionData,
        output stall_decode,
        output redirect,
        output redirectAddress,
        input  instruction_decode,
        input  pc_decode,
        input  valid_decode
    );

endinterface

`default_nettype wire

// File: rtl/jzjpcc_fetch_fifo.sv
// ============================================================================
// Module      : jzjpcc_fetch_fifo
// Description : Two-entry FIFO of fetch entries. entry0 is always the head;
//               a dequeue shifts entry1 down.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jzjpcc_fetch_fifo
    import jzjpcc_pkg::*;
(
    input  wire logic         clock,
    input  wire logic         reset_n,
    input  wire logic         enq,
    input  wire fetch_entry_t enq_entry,
    input  wire logic         deq,
    input  wire logic         flush,
    output logic [1:0]        count,
    output fetch_entry_t      head
);

    fetch_entry_t entry0;
    fetch_entry_t entry1;
    logic [1:0]   count_q;
    logic         enq_ok;
    logic         deq_ok;

    // A dequeue needs something to remove; an enqueue needs a free slot,
    // which a same-cycle dequeue provides
    assign deq_ok = deq & (count_q != 2'd0);
    assign enq_ok = enq & ((count_q != 2'd2) | deq_ok);

    // Storage and occupancy update; flush empties without touching data
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            entry0  <= '0;
            entry1  <= '0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({enq_ok, deq_ok})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        entry0 <= enq_entry;
                    end else begin
                        entry1 <= enq_entry;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    entry0  <= entry1;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        entry0 <= enq_entry;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= enq_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count = count_q;
    assign head  = entry0;

endmodule

`default_nettype wire

// File: rtl/jzjpcc_fetch_queue.sv
// ============================================================================
// Module      : jzjpcc_fetch_queue
// Description : Fetch stage: program counter, request issue with credit-based
//               flow control against a 2-entry queue, redirect flush, and NOP
//               substitution toward decode when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jzjpcc_fetch_queue
    import jzjpcc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  wire logic            clock,
    input  wire logic            reset_n,
    jzjpcc_fetch_queue_if.master bus
);

    logic [29:0]  pc_fetch;
    logic         inflight;
    logic [31:0]  inflight_pc;
    logic         drop;

    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t new_entry;
    logic         valid;
    logic         deq;
    logic         enq;
    logic         request;
    logic [2:0]   credit;
    logic         unused_redirect_bits;

    // Low address bits are word-alignment only and are discarded
    assign unused_redirect_bits = &{1'b0, bus.redirectAddress[1:0]};

    assign valid = (count != 2'd0);
    assign deq   = valid & ~bus.stall_decode & ~bus.redirect;

    // Occupancy once everything outstanding has landed; a request is only
    // issued when its response is guaranteed a slot
    assign credit  = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};
    assign request = reset_n & ~bus.redirect & (credit < 3'd2);

    // The response in the redirect cycle belongs to the old stream
    assign enq = inflight & ~drop & ~bus.redirect;

    assign new_entry.instruction = bus.instructionData;
    assign new_entry.pc          = inflight_pc;

    // PC and in-flight tracking; redirect overrides normal advance
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_fetch    <= RESET_VECTOR[31:2];
            inflight    <= 1'b0;
            inflight_pc <= 32'd0;
            drop        <= 1'b0;
        end else if (bus.redirect) begin
            pc_fetch    <= bus.redirectAddress[31:2];
            inflight    <= 1'b0;
            drop        <= 1'b0;
        end else begin
            inflight <= request;
            if (request) begin
                pc_fetch    <= pc_fetch + 30'd1;
                inflight_pc <= {pc_fetch, 2'b00};
            end
        end
    end

    jzjpcc_fetch_fifo u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .enq       (enq),
        .enq_entry (new_entry),
        .deq       (deq),
        .flush     (bus.redirect),
        .count     (count),
        .head      (head)
    );

    assign bus.instructionAddress = pc_fetch;
    assign bus.instructionRequest = request;
    assign bus.valid_decode       = valid;
    assign bus.instruction_decode = valid ? head.instruction : NOP_INSTRUCTION;
    assign bus.pc_decode          = valid ? head.pc : 32'd0;

endmodule

`default_nettype wire
